// File: rtl/mem_wb_stage_pkg.sv
// mem_pkg: shared definitions for the MEM/WB stage slice.
//   sizeT  - memory access size encodings (byte/half/word/doubleword)
//   stateT - write-back FSM states (IDLE, DW_HI)
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } sizeT;

    // DW_HI means the upper word of a doubleword load is still owed to the
    // register file.
    typedef enum logic {
        IDLE  = 1'b0,
        DW_HI = 1'b1
    } stateT;

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: groups the memory-stage input bundle and the register-file
// write port of the MEM/WB stage.
//   master - memory stage / register file side (drives in_*, flush)
//   slave  - the MEM/WB stage (drives wb_*, stall_up, misaligned)
//
// Handshake: an instruction is transferred on a rising edge where in_valid=1
// and stall_up=0. While stall_up=1 the producer must hold every in_* signal
// unchanged; the stage ignores them on that edge and accepts them on the
// first edge after stall_up drops. flush squashes the stage on the edge it
// is sampled high, regardless of stall_up.
interface mem_wb_stage_if #(
    parameter int REG_AW = 4,
    parameter int DW     = 32
);
    logic              in_valid;
    logic [DW-1:0]     in_result;
    logic [DW-1:0]     in_data_hi;
    logic [1:0]        in_addr_lo;
    logic              in_is_load;
    logic [1:0]        in_size;
    logic              in_signed;
    logic [REG_AW-1:0] in_rd;
    logic              in_reg_write;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DW-1:0]     wb_data;
    logic              stall_up;
    logic              misaligned;

    modport master (
        output in_valid, in_result, in_data_hi, in_addr_lo, in_is_load,
               in_size, in_signed, in_rd, in_reg_write, flush,
        input  wb_en, wb_rd, wb_data, stall_up, misaligned
    );

    modport slave (
        input  in_valid, in_result, in_data_hi, in_addr_lo, in_is_load,
               in_size, in_signed, in_rd, in_reg_write, flush,
        output wb_en, wb_rd, wb_data, stall_up, misaligned
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational load-data alignment.
//   word       in  raw memory word
//   addrLo     in  address bits [1:0]
//   size       in  access size (mem_pkg::sizeT encoding)
//   isSigned   in  sign-extend byte/halfword results
//   aligned    out lane-selected, extended value
//   misaligned out access not naturally aligned for its size
module load_align
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] word,
    input  logic [1:0]    addrLo,
    input  logic [1:0]    size,
    input  logic          isSigned,
    output logic [DW-1:0] aligned,
    output logic          misaligned
);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Little-endian lanes: addrLo=00 is bits 7:0. A halfword only looks at
    // addrLo[1]; an odd address is flagged but still read from that half.
    assign byteVal = word[{addrLo, 3'b000} +: 8];
    assign halfVal = word[{addrLo[1], 4'b0000} +: 16];

    always_comb begin
        aligned    = word;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                aligned = {{(DW-8){isSigned & byteVal[7]}}, byteVal};
            end
            SZ_HALF: begin
                aligned    = {{(DW-16){isSigned & halfVal[15]}}, halfVal};
                misaligned = addrLo[0];
            end
            default: begin
                aligned    = word;
                misaligned = (addrLo != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register. Registers the memory-stage result,
// aligns/extends sub-word loads and drives the register-file write port.
// A doubleword load writes rd then rd+1 on two consecutive cycles, stalling
// upstream for the second one.
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of mem_wb_stage_if (in_*, flush, wb_*, stall_up,
//            misaligned)
//   dbgState out current FSM state, for observation only
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DW     = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_wb_stage_if.slave      bus,
    output stateT              dbgState
);
    stateT             state;
    stateT             stateNext;
    logic              stallUp;

    logic [DW-1:0]     alignedData;
    logic              alignMis;
    logic [DW-1:0]     capData;
    logic              capMis;
    logic              startDw;

    logic              wbEn;
    logic [REG_AW-1:0] wbRd;
    logic [DW-1:0]     wbData;
    logic              misReg;
    logic [DW-1:0]     hiData;
    logic [REG_AW-1:0] hiRd;

    load_align #(.DW(DW)) uAlign (
        .word       (bus.in_result),
        .addrLo     (bus.in_addr_lo),
        .size       (bus.in_size),
        .isSigned   (bus.in_signed),
        .aligned    (alignedData),
        .misaligned (alignMis)
    );

    // Alignment applies to loads only; everything else passes straight through.
    assign capData = bus.in_is_load ? alignedData : bus.in_result;
    assign capMis  = bus.in_is_load & alignMis;

    // A doubleword that does not write the register file is just a
    // non-writing instruction and needs no second cycle.
    assign startDw = bus.in_valid & bus.in_is_load & bus.in_reg_write &
                     (bus.in_size == SZ_DWORD);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startDw) stateNext = DW_HI;
            DW_HI:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (bus.flush) stateNext = IDLE;
    end

    // Output logic: stall is a pure function of state so the producer sees it
    // for the whole cycle in which the hi word is being written.
    always_comb begin
        stallUp = 1'b0;
        if (state == DW_HI) stallUp = 1'b1;
    end

    // Write-back registers. Priority: reset, flush, pending hi word, new input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbEn   <= 1'b0;
            wbRd   <= '0;
            wbData <= '0;
            misReg <= 1'b0;
            hiData <= '0;
            hiRd   <= '0;
        end else if (bus.flush) begin
            wbEn   <= 1'b0;
            misReg <= 1'b0;
        end else if (state == DW_HI) begin
            wbEn   <= 1'b1;
            wbRd   <= hiRd;
            wbData <= hiData;
            misReg <= 1'b0;
        end else if (bus.in_valid) begin
            wbEn   <= bus.in_reg_write;
            wbRd   <= bus.in_rd;
            wbData <= capData;
            misReg <= capMis;
            if (startDw) begin
                hiData <= bus.in_data_hi;
                // Register index wraps naturally at the field width (15 -> 0).
                hiRd   <= bus.in_rd + 1'b1;
            end
        end else begin
            // Bubble: index and data hold their last values.
            wbEn   <= 1'b0;
            misReg <= 1'b0;
        end
    end

    assign bus.wb_en      = wbEn;
    assign bus.wb_rd      = wbRd;
    assign bus.wb_data    = wbData;
    assign bus.misaligned = misReg;
    assign bus.stall_up   = stallUp;
    assign dbgState       = state;
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline stage sitting directly downstream of the data-memory stage. It registers the memory stage's result, aligns and extends sub-word load data, and drives the register-file write port. A doubleword load is split into two write-back cycles, and the stage stalls upstream for one cycle while it does so.

## Interface
Parameters:
- REG_AW, 4: register index width (16 architectural registers).
- DW, 32: datapath width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction this cycle.
- in_result  in  DW  memory-stage mux output: load word or address/ALU value.
- in_data_hi  in  DW  second memory word (address+4); used only for doubleword.
- in_addr_lo  in  2  address bits [1:0] of the access.
- in_is_load  in  1  instruction is a load.
- in_size  in  2  data size: 00 byte, 01 halfword, 10 word, 11 doubleword.
- in_signed  in  1  sign-extend byte/halfword loads.
- in_rd  in  REG_AW  destination register.
- in_reg_write  in  1  instruction writes the register file.
- flush  in  1  synchronous squash of this stage.
- wb_en  out  1  register-file write enable.
- wb_rd  out  REG_AW  write index.
- wb_data  out  DW  write data.
- stall_up  out  1  upstream must hold its outputs this cycle.
- misaligned  out  1  registered flag: current write-back came from a misaligned load.

## Operation
- States: IDLE (no pending second word) and DW_HI (second doubleword word pending).
- IDLE, rising edge with in_valid=1 and flush=0:
  - Capture the instruction.
  - wb_en is set to in_reg_write, and wb_rd to in_rd.
  - wb_data is the aligned value described below.
  - If in_is_load=1, in_size=11 and in_reg_write=1: latch in_data_hi and (in_rd+1) mod 16, then go to DW_HI.
- Alignment (load only, otherwise wb_data = in_result):
  - Byte: byte lane selected by addr_lo, little-endian (00 → bits 7:0, 11 → bits 31:24). Zero- or sign-extended per in_signed.
  - Halfword: addr_lo[1] selects the half (0 → 15:0). Extended per in_signed. addr_lo[0]=1 sets misaligned; the data still uses addr_lo[1].
  - Word/doubleword: in_result unchanged. addr_lo≠00 sets misaligned.
- DW_HI:
  - stall_up=1 combinationally from state; inputs are ignored on this edge.
  - Next edge: wb_en=1, wb_rd=latched rd+1, wb_data=latched hi word, misaligned=0, state → IDLE.
- in_valid=0 in IDLE: wb_en=0 next cycle. wb_rd and wb_data keep their last values.
- flush=1 on an edge overrides everything: wb_en=0, misaligned=0, state → IDLE, and any pending hi word is discarded.
- stall_up is never asserted in IDLE.

## Timing
- Reset (asynchronous, any time, including mid-doubleword):
  - wb_en=0, wb_rd=0, wb_data=0, misaligned=0.
  - state=IDLE, so stall_up=0.
  - Pending hi word is dropped.
- Latency: one cycle from input capture edge to wb_* valid. Outputs are fully registered.
- Doubleword captured at edge N:
  - Cycle N+1: lo write (rd) on wb_*, stall_up=1.
  - Edge N+1: inputs ignored; upstream holds them.
  - Cycle N+2: hi write (rd+1) on wb_*, stall_up=0.
  - Edge N+2: held inputs are accepted.
- Back-to-back single-cycle instructions: one write-back per cycle, no bubbles.
- rd=15 doubleword: second write goes to register 0 (wrap).
- Doubleword with in_reg_write=0: treated as a single non-writing instruction; no DW_HI.

## Structure
- Shared package `mem_pkg`:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - State encoding for IDLE and DW_HI.
- Sub-module `load_align`: combinational byte/halfword lane select plus extension, with misaligned detection. Inputs are word, addr_lo, size and signed; outputs are aligned value and misaligned.
- Top: state register, capture registers, hi-word/rd+1 latch, flush/reset priority.

## Test plan
- Reset: hold reset_n=0 mid-doubleword. Outputs → 0 and stall_up → 0 immediately, with no clock.
- Signed byte: in_result=0x12F4_8000, addr_lo=10, size=00, signed=1, rd=3. Next cycle wb_en=1, wb_rd=3, wb_data=0xFFFF_FFF4. With signed=0, wb_data=0x0000_00F4.
- Halfword misaligned: in_result=0xABCD_1234, addr_lo=11, size=01, signed=0. wb_data=0x0000_ABCD, misaligned=1.
- Doubleword: lo=0x1111_1111, hi=0x2222_2222, rd=15.
  - Cycle N+1: wb_rd=15, data 0x1111_1111, stall_up=1.
  - Cycle N+2: wb_rd=0, data 0x2222_2222, stall_up=0.
  - The held next instruction writes in cycle N+3.
- Flush during DW_HI: flush=1 at edge N+1. Cycle N+2 has wb_en=0 and stall_up=0, and the hi word is never written.
- Non-load pass-through: in_is_load=0, in_result=0x0000_0100, rd=7, followed by in_valid=0. Exactly one cycle of wb_en=1 with data 0x100, then wb_en=0.
